// File: rtl/mips_pkg.sv
// Shared MIPS opcode/funct constants and opcode-class helpers for the decode slice.
package mips_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_J     = 6'h02;
    localparam opcode_t OP_JAL   = 6'h03;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_BNE   = 6'h05;
    localparam opcode_t OP_ADDI  = 6'h08;
    localparam opcode_t OP_ADDIU = 6'h09;
    localparam opcode_t OP_SLTI  = 6'h0A;
    localparam opcode_t OP_SLTIU = 6'h0B;
    localparam opcode_t OP_ANDI  = 6'h0C;
    localparam opcode_t OP_ORI   = 6'h0D;
    localparam opcode_t OP_XORI  = 6'h0E;
    localparam opcode_t OP_LUI   = 6'h0F;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;

    localparam funct_t FN_JR = 6'h08;

    // Logical immediates are zero-extended; everything else (SLTIU included) is sign-extended.
    function automatic logic op_zero_ext(input opcode_t op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
    endfunction

    function automatic logic op_is_legal(input opcode_t op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW: legal = 1'b1;
            default:      legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational field split and class-flag decode of one instruction word.
module instr_field_decode
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16
) (
    input  logic [XLEN-1:0]  instr,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [IMM_W-1:0] imm16,
    output logic             imm_u,
    output logic             is_rtype,
    output logic             is_branch,
    output logic             is_jump,
    output logic             illegal
);

    always_comb begin
        opcode = instr[31:26];
        rs     = instr[25:21];
        rt     = instr[20:16];
        rd     = instr[15:11];
        shamt  = instr[10:6];
        funct  = instr[5:0];
        imm16  = instr[IMM_W-1:0];
    end

    always_comb begin
        imm_u     = op_zero_ext(opcode);
        is_rtype  = (opcode == OP_RTYPE);
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jump   = (opcode == OP_J) || (opcode == OP_JAL) ||
                    ((opcode == OP_RTYPE) && (funct == FN_JR));
        illegal   = !op_is_legal(opcode);
    end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline stage: two-entry (main + skid) buffer with registered in_ready,
// flush and async reset; fields are decoded from the main register.
module if_id_decode
    import mips_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [IMM_W-1:0] imm16,
    output logic             imm_u,
    output logic             is_rtype,
    output logic             is_branch,
    output logic             is_jump,
    output logic             illegal
);

    logic            main_valid;
    logic [XLEN-1:0] main_instr;
    logic [XLEN-1:0] main_pc;
    logic            skid_valid;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic accept;
    logic main_free;

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign main_free = !main_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_instr <= '0;
            main_pc    <= '0;
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // Skid is only ever full while in_ready is low, so accept and skid refill never coincide.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_instr <= skid_instr;
                main_pc    <= skid_pc;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_instr <= in_instr;
                main_pc    <= in_pc;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
        end
    end

    assign out_valid = main_valid;
    assign out_pc    = main_pc;

    instr_field_decode #(
        .XLEN  (XLEN),
        .IMM_W (IMM_W)
    ) u_dec (
        .instr     (main_instr),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm16     (imm16),
        .imm_u     (imm_u),
        .is_rtype  (is_rtype),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .illegal   (illegal)
    );

endmodule

// File: tb/tb_if_id_decode.sv
// Directed self-checking bench for if_id_decode: decode vectors, backpressure, flush, async reset.
module tb_if_id_decode;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        imm_u;
    logic        is_rtype;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    if_id_decode #(
        .XLEN  (32),
        .IMM_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .imm16     (imm16),
        .imm_u     (imm_u),
        .is_rtype  (is_rtype),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        @(negedge clk);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_pc",    out_pc,             32'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;

        // ORI $8,$8,0x00FF : rs=8, rt=8 (bits 25:21 and 20:16 of 0x3508_00FF)
        drive(1'b1, 32'h3508_00FF, 32'h0000_0100);
        step();
        chk("ori_valid",   {31'b0, out_valid}, 32'd1);
        chk("ori_pc",      out_pc,             32'h100);
        chk("ori_opcode",  {26'b0, opcode},    32'h0D);
        chk("ori_rs",      {27'b0, rs},        32'd8);
        chk("ori_rt",      {27'b0, rt},        32'd8);
        chk("ori_imm16",   {16'b0, imm16},     32'h00FF);
        chk("ori_imm_u",   {31'b0, imm_u},     32'd1);
        chk("ori_illegal", {31'b0, illegal},   32'd0);

        // ADDI: sign-extended immediate
        drive(1'b1, 32'h2108_FFFC, 32'h0000_0104);
        step();
        chk("addi_pc",    out_pc,         32'h104);
        chk("addi_imm_u", {31'b0, imm_u}, 32'd0);
        chk("addi_imm16", {16'b0, imm16}, 32'hFFFC);

        // SLTIU stays sign-extended
        drive(1'b1, 32'h2D08_8000, 32'h0000_0108);
        step();
        chk("sltiu_opcode", {26'b0, opcode}, 32'h0B);
        chk("sltiu_imm_u",  {31'b0, imm_u},  32'd0);

        // LUI zero-extends
        drive(1'b1, 32'h3C01_1234, 32'h0000_010C);
        step();
        chk("lui_imm_u", {31'b0, imm_u}, 32'd1);

        // JR: R-type with funct 0x08
        drive(1'b1, 32'h0000_0008, 32'h0000_0110);
        step();
        chk("jr_rtype",  {31'b0, is_rtype},  32'd1);
        chk("jr_jump",   {31'b0, is_jump},   32'd1);
        chk("jr_branch", {31'b0, is_branch}, 32'd0);
        chk("jr_funct",  {26'b0, funct},     32'h08);

        // BEQ
        drive(1'b1, 32'h1000_0003, 32'h0000_0114);
        step();
        chk("beq_branch", {31'b0, is_branch}, 32'd1);
        chk("beq_jump",   {31'b0, is_jump},   32'd0);
        chk("beq_rtype",  {31'b0, is_rtype},  32'd0);

        // JAL (opcode 0x03)
        drive(1'b1, 32'h0C00_0000, 32'h0000_0118);
        step();
        chk("jal_jump",  {31'b0, is_jump}, 32'd1);
        chk("jal_imm_u", {31'b0, imm_u},   32'd0);

        // Opcode 0x3F illegal but still passed through
        drive(1'b1, 32'hFC00_0000, 32'h0000_011C);
        step();
        chk("op3f_valid",   {31'b0, out_valid}, 32'd1);
        chk("op3f_illegal", {31'b0, illegal},   32'd1);

        // LW legal, opcode 0x06 illegal
        drive(1'b1, 32'h8C00_0000, 32'h0000_0120);
        step();
        chk("lw_illegal", {31'b0, illegal}, 32'd0);
        drive(1'b1, 32'h1800_0000, 32'h0000_0124);
        step();
        chk("op06_illegal", {31'b0, illegal}, 32'd1);

        drive(1'b0, '0, '0);
        step();
        chk("drain_empty", {31'b0, out_valid}, 32'd0);

        // Backpressure: A, B, C offered while out_ready=0
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h2108_0001;
        in_pc     = 32'h200;
        step();
        chk("bp_a_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_a_pc",    out_pc,             32'h200);
        chk("bp_a_ready", {31'b0, in_ready},  32'd1);
        drive(1'b1, 32'h2108_0002, 32'h204);
        step();
        chk("bp_b_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_b_hold",  out_pc,            32'h200);
        drive(1'b1, 32'h2108_0003, 32'h208);
        step();
        chk("bp_c_ready", {31'b0, in_ready},  32'd0);
        chk("bp_c_hold",  out_pc,             32'h200);
        chk("bp_c_imm",   {16'b0, imm16},     32'h0001);
        @(negedge clk);
        out_ready = 1'b1;
        step();
        chk("bp_out_b",    out_pc,            32'h204);
        chk("bp_b_rdy_up", {31'b0, in_ready}, 32'd1);
        step();
        chk("bp_out_c",       out_pc,             32'h208);
        chk("bp_out_c_valid", {31'b0, out_valid}, 32'd1);
        drive(1'b0, '0, '0);
        step();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

        // Flush with main and skid full, input offered
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h2108_0010;
        in_pc     = 32'h300;
        step();
        drive(1'b1, 32'h2108_0011, 32'h304);
        step();
        chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush    = 1'b1;
        in_instr = 32'h2108_0012;
        in_pc    = 32'h308;
        step();
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl_no_ghost", {31'b0, out_valid}, 32'd0);

        // Flush with main only: accepted input and out_ready both ignored
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h2108_0020;
        in_pc     = 32'h400;
        step();
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_instr  = 32'h2108_0021;
        in_pc     = 32'h404;
        step();
        chk("fl2_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl2_no_ghost", {31'b0, out_valid}, 32'd0);

        // Async reset mid-stream with two held
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h2108_0030;
        in_pc     = 32'h500;
        step();
        drive(1'b1, 32'h2108_0031, 32'h504);
        step();
        chk("rs_full_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_ready", {31'b0, in_ready},  32'd1);
        chk("rs_pc",    out_pc,             32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h3508_00AA;
        in_pc     = 32'h600;
        step();
        chk("rs_first_valid", {31'b0, out_valid}, 32'd1);
        chk("rs_first_pc",    out_pc,             32'h600);
        chk("rs_first_imm",   {16'b0, imm16},     32'h00AA);
        drive(1'b0, '0, '0);
        step();
        chk("rs_drained", {31'b0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
